l1_l2_arbiter: RTL and testbench

Registered, parametrised arbiter between NUM_REQ L1 caches (requester 0 = L1I, 1 = L1D by convention) and the shared L2 request port. It generalises the L1I/L1D to L2 connection in three ways:
- It handles N requesters.
- It offers fixed-priority or round-robin arbitration.
- It locks the grant for the whole L2 transaction instead of muxing combinationally every cycle, so index/tag/op stay stable until L2 answers.

---
 rtl/l1_l2_pkg.sv | 21 ++
 rtl/rr_pick.sv | 42 ++++
 rtl/l1_l2_arbiter.sv | 156 +++++++++++++++
 tb/tb_l1_l2_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_l2_pkg.sv
// Shared definitions for the L1-to-L2 request path.
//   state_t     : arbiter FSM states
//   op_t        : L2 operation selected for a granted requester
//   DEF_INDEX_W : default cache index width shared with the cache modules
//   DEF_TAG_W   : default tag width shared with the cache modules
package l1_l2_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

    localparam int DEF_INDEX_W = 4;
    localparam int DEF_TAG_W   = 22;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner picker, shared by the L1->L2 and L2->memory arbiters.
//   active    in  N     request vector
//   ptr       in  ID_W  first index to consider when rr_mode is set
//   rr_mode   in  1     0 = lowest active index wins, 1 = search from ptr with wrap
//   winner_oh out N     one-hot winner (all zero when nothing is active)
//   winner_id out ID_W  binary winner
//   valid     out 1     at least one requester active
module rr_pick #(
    parameter int   N    = 2,
    localparam int  ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    active,
    input  logic [ID_W-1:0] ptr,
    input  logic            rr_mode,
    output logic [N-1:0]    winner_oh,
    output logic [ID_W-1:0] winner_id,
    output logic            valid
);

    always_comb begin
        int unsigned start;
        int unsigned idx;
        winner_oh = '0;
        winner_id = '0;
        valid     = |active;
        start     = '0;
        if (rr_mode) begin
            start = {{(32-ID_W){1'b0}}, ptr};
        end
        // Walk the search order backwards so the last hit is the one
        // closest to the start position.
        for (int unsigned off = N; off > 0; off--) begin
            idx = (start + off - 1) % N;
            if (active[idx]) begin
                winner_oh      = '0;
                winner_oh[idx] = 1'b1;
                winner_id      = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/l1_l2_arbiter.sv
// Registered arbiter between NUM_REQ L1 caches and the shared L2 request port.
// The grant is locked for the whole L2 transaction, so op/index/tag stay
// stable until L2 signals completion.
//   clk, nrst            clock, asynchronous active-low reset
//   read_req, write_req  per-requester read / write-back requests
//   rd_index, rd_tag     per-requester read address (requester k at slice k)
//   wr_index, wr_tag     per-requester write-back address
//   ready_L2_L1          L2 completion strobe
//   ready_L2_req         completion strobe routed to the granted requester
//   read_L1_L2, write_L1_L2, index_L1_L2, tag_L1_L2  registered L2 request
//   grant_id             currently / last granted requester
//   busy                 transaction in flight
module l1_l2_arbiter
    import l1_l2_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    parameter int  INDEX_W = DEF_INDEX_W,
    parameter int  TAG_W   = DEF_TAG_W,
    parameter int  RR_MODE = 0,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [NUM_REQ-1:0]         read_req,
    input  logic [NUM_REQ-1:0]         write_req,
    input  logic [NUM_REQ*INDEX_W-1:0] rd_index,
    input  logic [NUM_REQ*TAG_W-1:0]   rd_tag,
    input  logic [NUM_REQ*INDEX_W-1:0] wr_index,
    input  logic [NUM_REQ*TAG_W-1:0]   wr_tag,
    input  logic                       ready_L2_L1,
    output logic [NUM_REQ-1:0]         ready_L2_req,
    output logic                       read_L1_L2,
    output logic                       write_L1_L2,
    output logic [INDEX_W-1:0]         index_L1_L2,
    output logic [TAG_W-1:0]           tag_L1_L2,
    output logic [ID_W-1:0]            grant_id,
    output logic                       busy
);

    state_t             state_q, state_n;
    logic               read_q, read_n;
    logic               write_q, write_n;
    logic [INDEX_W-1:0] index_q, index_n;
    logic [TAG_W-1:0]   tag_q, tag_n;
    logic [ID_W-1:0]    grant_q, grant_n;
    logic [ID_W-1:0]    ptr_q, ptr_n;

    logic [NUM_REQ-1:0] active;
    logic [NUM_REQ-1:0] win_oh;
    logic [ID_W-1:0]    win_id;
    logic               win_valid;

    op_t                op_sel;
    logic [INDEX_W-1:0] index_sel;
    logic [TAG_W-1:0]   tag_sel;

    assign active = read_req | write_req;

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .active    (active),
        .ptr       (ptr_q),
        .rr_mode   (RR_MODE != 0),
        .winner_oh (win_oh),
        .winner_id (win_id),
        .valid     (win_valid)
    );

    // Winner's op and address; read has priority over write within a requester.
    always_comb begin
        op_sel    = OP_READ;
        index_sel = '0;
        tag_sel   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (win_oh[k]) begin
                if (read_req[k]) begin
                    op_sel    = OP_READ;
                    index_sel = rd_index[k*INDEX_W +: INDEX_W];
                    tag_sel   = rd_tag[k*TAG_W +: TAG_W];
                end else begin
                    op_sel    = OP_WRITE;
                    index_sel = wr_index[k*INDEX_W +: INDEX_W];
                    tag_sel   = wr_tag[k*TAG_W +: TAG_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            index_q <= '0;
            tag_q   <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_n;
            read_q  <= read_n;
            write_q <= write_n;
            index_q <= index_n;
            tag_q   <= tag_n;
            grant_q <= grant_n;
            ptr_q   <= ptr_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        read_n       = read_q;
        write_n      = write_q;
        index_n      = index_q;
        tag_n        = tag_q;
        grant_n      = grant_q;
        ptr_n        = ptr_q;
        ready_L2_req = '0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_n = BUSY;
                    grant_n = win_id;
                    read_n  = (op_sel == OP_READ);
                    write_n = (op_sel == OP_WRITE);
                    index_n = index_sel;
                    tag_n   = tag_sel;
                end
            end
            BUSY: begin
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    ready_L2_req[k] = ready_L2_L1 && (grant_q == ID_W'(k));
                end
                if (ready_L2_L1) begin
                    state_n = IDLE;
                    read_n  = 1'b0;
                    write_n = 1'b0;
                    index_n = '0;
                    tag_n   = '0;
                    if (RR_MODE != 0) begin
                        ptr_n = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign read_L1_L2  = read_q;
    assign write_L1_L2 = write_q;
    assign index_L1_L2 = index_q;
    assign tag_L1_L2   = tag_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q == BUSY);

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Self-checking bench: instance A (2 requesters, fixed priority) and
// instance B (3 requesters, round-robin) against a transaction-level model.
module tb_l1_l2_arbiter;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    // Instance A: NUM_REQ=2, RR_MODE=0
    logic [1:0]  a_rd, a_wr, a_rl2;
    logic [7:0]  a_rdi, a_wri;
    logic [43:0] a_rdt, a_wrt;
    logic        a_ready, a_read, a_write, a_busy;
    logic [3:0]  a_idx;
    logic [21:0] a_tag;
    logic [0:0]  a_gid;

    // Instance B: NUM_REQ=3, RR_MODE=1
    logic [2:0]  b_rd, b_wr, b_rl2;
    logic [11:0] b_rdi, b_wri;
    logic [65:0] b_rdt, b_wrt;
    logic        b_ready, b_read, b_write, b_busy;
    logic [3:0]  b_idx;
    logic [21:0] b_tag;
    logic [1:0]  b_gid;

    l1_l2_arbiter #(.NUM_REQ(2), .INDEX_W(4), .TAG_W(22), .RR_MODE(0)) u_a (
        .clk(clk), .nrst(nrst), .read_req(a_rd), .write_req(a_wr),
        .rd_index(a_rdi), .rd_tag(a_rdt), .wr_index(a_wri), .wr_tag(a_wrt),
        .ready_L2_L1(a_ready), .ready_L2_req(a_rl2), .read_L1_L2(a_read),
        .write_L1_L2(a_write), .index_L1_L2(a_idx), .tag_L1_L2(a_tag),
        .grant_id(a_gid), .busy(a_busy)
    );

    l1_l2_arbiter #(.NUM_REQ(3), .INDEX_W(4), .TAG_W(22), .RR_MODE(1)) u_b (
        .clk(clk), .nrst(nrst), .read_req(b_rd), .write_req(b_wr),
        .rd_index(b_rdi), .rd_tag(b_rdt), .wr_index(b_wri), .wr_tag(b_wrt),
        .ready_L2_L1(b_ready), .ready_L2_req(b_rl2), .read_L1_L2(b_read),
        .write_L1_L2(b_write), .index_L1_L2(b_idx), .tag_L1_L2(b_tag),
        .grant_id(b_gid), .busy(b_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model, one slot per instance.
    bit          m_busy[2];
    bit          m_read[2];
    bit          m_write[2];
    int          m_grant[2];
    int          m_ptr[2];
    logic [3:0]  m_idx[2];
    logic [21:0] m_tag[2];

    logic [30:0] act_a, act_b;
    assign act_a = {a_read, a_write, a_idx, a_tag, 1'b0, a_gid, a_busy};
    assign act_b = {b_read, b_write, b_idx, b_tag, b_gid, b_busy};

    function automatic logic [30:0] exp_vec(input int i);
        return {m_read[i], m_write[i], m_idx[i], m_tag[i], 2'(m_grant[i]), m_busy[i]};
    endfunction

    function automatic logic [2:0] exp_rdy(input int i, input logic rdy);
        return (m_busy[i] && rdy) ? 3'(1 << m_grant[i]) : 3'b000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_read[i] = 0; m_write[i] = 0;
            m_grant[i] = 0; m_ptr[i] = 0; m_idx[i] = '0; m_tag[i] = '0;
        end
    endtask

    // One clock edge of the arbitration rules for instance 'inst'.
    task automatic model_step(input int inst, input int n, input bit rr,
                              input logic [2:0] rd, input logic [2:0] wr,
                              input logic [11:0] rdi, input logic [11:0] wri,
                              input logic [65:0] rdt, input logic [65:0] wrt,
                              input logic rdy);
        int w;
        int k;
        w = -1;
        if (!m_busy[inst]) begin
            for (int off = 0; off < n; off++) begin
                k = ((rr ? m_ptr[inst] : 0) + off) % n;
                if (w < 0 && (rd[k] || wr[k])) w = k;
            end
            if (w >= 0) begin
                m_busy[inst]  = 1;
                m_grant[inst] = w;
                m_read[inst]  = rd[w];
                m_write[inst] = !rd[w];
                m_idx[inst]   = rd[w] ? rdi[w*4 +: 4]   : wri[w*4 +: 4];
                m_tag[inst]   = rd[w] ? rdt[w*22 +: 22] : wrt[w*22 +: 22];
            end
        end else if (rdy) begin
            m_busy[inst] = 0; m_read[inst] = 0; m_write[inst] = 0;
            m_idx[inst] = '0; m_tag[inst] = '0;
            if (rr) m_ptr[inst] = (m_grant[inst] + 1) % n;
        end
    endtask

    // Advance one clock: model sees the current inputs, then the edge, then #1.
    task automatic tick();
        model_step(0, 2, 1'b0, {1'b0, a_rd}, {1'b0, a_wr}, {4'b0, a_rdi}, {4'b0, a_wri},
                   {22'b0, a_rdt}, {22'b0, a_wrt}, a_ready);
        model_step(1, 3, 1'b1, b_rd, b_wr, b_rdi, b_wri, b_rdt, b_wrt, b_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a_rd = '0; a_wr = '0; a_rdi = '0; a_wri = '0; a_rdt = '0; a_wrt = '0; a_ready = 0;
        b_rd = '0; b_wr = '0; b_rdi = '0; b_wri = '0; b_rdt = '0; b_wrt = '0; b_ready = 0;
    endtask

    task automatic test_reset();
        nrst = 0;
        clear_inputs();
        a_rd = 2'b11; a_ready = 1; b_rd = 3'b111; b_ready = 1;
        #12;
        n_checks++;
        if (act_a !== 31'h0) begin n_fail++; $display("FAIL reset_a: got %h expected %h", act_a, 31'h0); end
        n_checks++;
        if (act_b !== 31'h0) begin n_fail++; $display("FAIL reset_b: got %h expected %h", act_b, 31'h0); end
        n_checks++;
        if ({a_rl2, b_rl2} !== 5'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 00000", {a_rl2, b_rl2}); end
        clear_inputs();
        nrst = 1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_fixed_priority();
        a_rd = 2'b11; a_rdi = {4'h5, 4'h3}; a_rdt = {22'h2, 22'h1};
        #1;
        n_checks++;
        if (a_read !== 1'b0) begin n_fail++; $display("FAIL fp_same_cycle: got %b expected 0", a_read); end
        tick();
        n_checks++;
        if (act_a !== {1'b1, 1'b0, 4'h3, 22'h1, 2'b00, 1'b1}) begin
            n_fail++; $display("FAIL fp_grant0: got %h expected %h", act_a, {1'b1, 1'b0, 4'h3, 22'h1, 2'b00, 1'b1});
        end
        tick();
        tick();
        n_checks++;
        if (act_a !== exp_vec(0)) begin n_fail++; $display("FAIL fp_hold: got %h expected %h", act_a, exp_vec(0)); end
        a_ready = 1;
        #1;
        n_checks++;
        if (a_rl2 !== 2'b01) begin n_fail++; $display("FAIL fp_ready_route: got %b expected 01", a_rl2); end
        tick();
        a_ready = 0;
        n_checks++;
        if (act_a !== 31'h0) begin n_fail++; $display("FAIL fp_release: got %h expected %h", act_a, 31'h0); end
        a_rd = 2'b10;
        tick();
        n_checks++;
        if (act_a !== {1'b1, 1'b0, 4'h5, 22'h2, 2'b01, 1'b1}) begin
            n_fail++; $display("FAIL fp_grant1: got %h expected %h", act_a, {1'b1, 1'b0, 4'h5, 22'h2, 2'b01, 1'b1});
        end
        a_ready = 1;
        #1;
        n_checks++;
        if (a_rl2 !== 2'b10) begin n_fail++; $display("FAIL fp_ready_route1: got %b expected 10", a_rl2); end
        tick();
        clear_inputs();
    endtask

    task automatic test_round_robin();
        int seq[4] = '{0, 1, 0, 1};
        b_rd = 3'b011; b_rdi = {4'h3, 4'h2, 4'h1}; b_rdt = {22'h33, 22'h22, 22'h11};
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (b_gid !== 2'(seq[i]) || act_b !== exp_vec(1)) begin
                n_fail++; $display("FAIL rr_seq%0d: got id %0d vec %h expected id %0d vec %h", i, b_gid, act_b, seq[i], exp_vec(1));
            end
            b_ready = 1;
            #1;
            n_checks++;
            if (b_rl2 !== 3'(1 << seq[i])) begin n_fail++; $display("FAIL rr_ready%0d: got %b expected %b", i, b_rl2, 3'(1 << seq[i])); end
            tick();
            b_ready = 0;
        end
    endtask

    // Pointer is 2 after test_round_robin; active 011 must wrap to requester 0.
    task automatic test_rr_wrap();
        tick();
        n_checks++;
        if (b_gid !== 2'd0 || b_idx !== 4'h1) begin n_fail++; $display("FAIL rr_wrap: got id %0d idx %h expected id 0 idx 1", b_gid, b_idx); end
        b_ready = 1;
        tick();
        b_ready = 0;
        b_rd = 3'b101;
        tick();
        n_checks++;
        if (b_gid !== 2'd2 || act_b !== exp_vec(1)) begin n_fail++; $display("FAIL rr_ptr1: got id %0d vec %h expected id 2 vec %h", b_gid, act_b, exp_vec(1)); end
        b_ready = 1;
        tick();
        clear_inputs();
    endtask

    task automatic test_read_over_write();
        a_rd = 2'b10; a_wr = 2'b10; a_rdi = {4'hA, 4'h0}; a_wri = {4'hC, 4'h0};
        a_rdt = {22'h0AAAA, 22'h0}; a_wrt = {22'h0CCCC, 22'h0};
        tick();
        n_checks++;
        if ({a_read, a_write, a_idx, a_gid} !== {1'b1, 1'b0, 4'hA, 1'b1}) begin
            n_fail++; $display("FAIL rw_read_first: got %b expected %b", {a_read, a_write, a_idx, a_gid}, {1'b1, 1'b0, 4'hA, 1'b1});
        end
        a_ready = 1;
        tick();
        a_ready = 0;
        a_rd = 2'b00;
        tick();
        n_checks++;
        if ({a_read, a_write, a_idx, a_tag} !== {1'b0, 1'b1, 4'hC, 22'h0CCCC}) begin
            n_fail++; $display("FAIL rw_write_later: got %h expected %h", {a_read, a_write, a_idx, a_tag}, {1'b0, 1'b1, 4'hC, 22'h0CCCC});
        end
        a_ready = 1;
        tick();
        clear_inputs();
    endtask

    task automatic test_hold_while_busy();
        logic [21:0] t;
        t = 22'($urandom);
        a_rd = 2'b01; a_rdi = {4'h0, 4'h7}; a_rdt = {22'h0, t};
        tick();
        for (int i = 0; i < 3; i++) begin
            a_rd  = 2'($urandom) & 2'b10;
            a_wr  = 2'($urandom);
            a_rdi = 8'($urandom) | 8'h08;
            a_rdt = {22'($urandom), ~t};
            tick();
            n_checks++;
            if (act_a !== {1'b1, 1'b0, 4'h7, t, 2'b00, 1'b1}) begin
                n_fail++; $display("FAIL hold%0d: got %h expected %h", i, act_a, {1'b1, 1'b0, 4'h7, t, 2'b00, 1'b1});
            end
        end
        a_rd = '0; a_wr = '0;
        a_ready = 1;
        tick();
        a_ready = 0;
        n_checks++;
        if (act_a !== 31'h0) begin n_fail++; $display("FAIL hold_release: got %h expected %h", act_a, 31'h0); end
        clear_inputs();
    endtask

    task automatic test_idle_ready_and_reset();
        a_ready = 1; b_ready = 1;
        #1;
        n_checks++;
        if ({a_rl2, b_rl2} !== 5'b0) begin n_fail++; $display("FAIL idle_ready: got %b expected 00000", {a_rl2, b_rl2}); end
        tick();
        a_ready = 0; b_ready = 0;
        n_checks++;
        if (act_a !== exp_vec(0) || act_b !== exp_vec(1) || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_ready_state: got %h %h expected %h %h", act_a, act_b, exp_vec(0), exp_vec(1));
        end
        // Move B's pointer off zero, then reset in the middle of a transaction.
        b_rd = 3'b010; b_rdi = 12'h123; b_rdt = 66'h1;
        tick();
        b_ready = 1;
        tick();
        b_ready = 0;
        b_rd = 3'b001; a_rd = 2'b01; a_rdi = 8'h0F; a_rdt = 44'h5;
        tick();
        #2;
        nrst = 0;
        #1;
        n_checks++;
        if (act_a !== 31'h0 || act_b !== 31'h0) begin
            n_fail++; $display("FAIL async_reset: got %h %h expected 0 0", act_a, act_b);
        end
        clear_inputs();
        model_reset();
        nrst = 1;
        @(posedge clk);
        #1;
        b_rd = 3'b110; b_rdi = 12'h456; b_rdt = {22'h6, 22'h5, 22'h4};
        tick();
        n_checks++;
        if (b_gid !== 2'd1 || act_b !== exp_vec(1)) begin
            n_fail++; $display("FAIL reset_ptr: got id %0d vec %h expected id 1 vec %h", b_gid, act_b, exp_vec(1));
        end
        b_ready = 1;
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            a_rd = 2'($urandom) & 2'($urandom);
            a_wr = 2'($urandom) & 2'($urandom);
            a_rdi = 8'($urandom); a_wri = 8'($urandom);
            a_rdt = {22'($urandom), 22'($urandom)}; a_wrt = {22'($urandom), 22'($urandom)};
            a_ready = ($urandom_range(0, 2) == 0);
            b_rd = 3'($urandom) & 3'($urandom);
            b_wr = 3'($urandom) & 3'($urandom);
            b_rdi = 12'($urandom); b_wri = 12'($urandom);
            b_rdt = {22'($urandom), 22'($urandom), 22'($urandom)};
            b_wrt = {22'($urandom), 22'($urandom), 22'($urandom)};
            b_ready = ($urandom_range(0, 2) == 0);
            #1;
            n_checks++;
            if ({1'b0, a_rl2} !== exp_rdy(0, a_ready) || b_rl2 !== exp_rdy(1, b_ready)) begin
                n_fail++; $display("FAIL rand_ready%0d: got %b %b expected %b %b", c, a_rl2, b_rl2, exp_rdy(0, a_ready), exp_rdy(1, b_ready));
            end
            tick();
            n_checks++;
            if (act_a !== exp_vec(0) || act_b !== exp_vec(1)) begin
                n_fail++; $display("FAIL rand_out%0d: got %h %h expected %h %h", c, act_a, act_b, exp_vec(0), exp_vec(1));
            end
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_rr_wrap();
        test_read_over_write();
        test_hold_while_busy();
        test_idle_ready_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
